shared_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-bit D-flip-flop register between N_REQ requesters.
- Each requester presents request plus write data; the winner's data is captured into the shared register.
- A requester may hold ownership across cycles with a lock line.
- Sits between client blocks and the common storage register; it is the only writer of that register.

---
 rtl/shared_reg_arb_pkg.sv | 21 ++
 rtl/shared_reg_arbiter_rr_pick.sv | 29 ++
 rtl/shared_reg_arbiter.sv | 122 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// state encoding, index-width helper and one-hot helper.
package shared_reg_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping past the top index back to zero.
module rr_pick import shared_reg_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  int slot;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    slot   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      slot = int'(ptr) + i;
      if (slot >= N_REQ) slot = slot - N_REQ;
      if (!any && req[slot]) begin
        any    = 1'b1;
        winner = IDX_W'(slot);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared DATA_W register, with per-requester lock.
// Optional forced lock release after MAX_LOCK grants: define ARB_TIMEOUT_EN.
module shared_reg_arbiter import shared_reg_arb_pkg::*; #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*DATA_W-1:0]    wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [idx_w(N_REQ)-1:0]    owner,
  output logic [DATA_W-1:0]          q,
  output logic                       q_valid,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IDX_W = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > MAX_REQ || MAX_LOCK < 1) begin : g_bad_params
    $error("shared_reg_arbiter: unsupported N_REQ/MAX_LOCK");
  end

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic              any;
  logic [IDX_W-1:0]  winner;
  logic              hold;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] own_data;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  assign win_data = wdata[winner*DATA_W +: DATA_W];
  assign own_data = wdata[owner*DATA_W +: DATA_W];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  logic [CNT_W-1:0] lock_cnt;
  logic             expired;
  // lock_cnt counts grants already given in this lock, including the entry grant
  assign expired = (lock_cnt == CNT_W'(MAX_LOCK));
  assign hold    = req[owner] & lock[owner] & ~expired;
`else
  assign hold    = req[owner] & lock[owner];
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      owner   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      lock_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any) begin
            q       <= win_data;
            gnt     <= N_REQ'(onehot(MAX_IDX_W'(winner)));
            owner   <= winner;
            q_valid <= 1'b1;
            if (lock[winner]) begin
              state <= LOCKED;
              busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
              lock_cnt <= CNT_W'(1);
`endif
            end else begin
              ptr <= next_idx(winner);
            end
          end else begin
            gnt <= '0;
          end
        end
        LOCKED: begin
          if (hold) begin
            q   <= own_data;
            gnt <= N_REQ'(onehot(MAX_IDX_W'(owner)));
`ifdef ARB_TIMEOUT_EN
            lock_cnt <= lock_cnt + 1'b1;
`endif
          end else begin
            // release edge writes nothing, so arbitration restarts one cycle later
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= next_idx(owner);
            state <= IDLE;
`ifdef ARB_TIMEOUT_EN
            timeout  <= req[owner] & lock[owner];
            lock_cnt <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int ML = 8;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  lock  = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]  gnt;
  logic [1:0]    owner;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          busy;
  logic          timeout;

  shared_reg_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  int            m_cnt;
  logic [N-1:0]  m_gnt;
  logic [DW-1:0] m_q;
  bit            m_valid;
  bit            m_timeout;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane(int i);
    return wdata[i*DW +: DW];
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    m_gnt = '0; m_q = '0; m_valid = 0; m_timeout = 0;
  endtask

  task automatic model_edge();
    bit found;
    bit keep;
    int w;
    found = 0;
    w = 0;
    m_timeout = 0;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && req[j]) begin found = 1; w = j; end
      end
      if (found) begin
        m_q = lane(w); m_gnt = N'(1 << w); m_owner = w; m_valid = 1;
        if (lock[w]) begin m_locked = 1; m_cnt = 1; end
        else m_ptr = (w + 1) % N;
      end else begin
        m_gnt = '0;
      end
    end else begin
      keep = req[m_owner] && lock[m_owner];
`ifdef ARB_TIMEOUT_EN
      if (keep && m_cnt >= ML) begin keep = 0; m_timeout = 1; end
`endif
      if (keep) begin
        m_q = lane(m_owner); m_gnt = N'(1 << m_owner); m_cnt++;
      end else begin
        m_gnt = '0; m_locked = 0; m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic check_all(string tag);
    check_val({tag, ".gnt"},     32'(gnt),     32'(m_gnt));
    check_val({tag, ".owner"},   32'(owner),   32'(m_owner));
    check_val({tag, ".q"},       32'(q),       32'(m_q));
    check_val({tag, ".q_valid"}, 32'(q_valid), 32'(m_valid));
    check_val({tag, ".busy"},    32'(busy),    32'(m_locked));
    check_val({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // called 1 time unit after a rising edge; asserts reset between edges
  task automatic async_reset(string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_val({tag, ".gnt0"},   32'(gnt),     32'h0);
    check_val({tag, ".q0"},     32'(q),       32'h0);
    check_val({tag, ".busy0"},  32'(busy),    32'h0);
    check_val({tag, ".owner0"}, 32'(owner),   32'h0);
    check_val({tag, ".valid0"}, 32'(q_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n_g0;
    int n_to;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // single request from requester 2
    req = 4'b0100; wdata = 32'h00A5_0000;
    cycle("single");
    check_val("single.gnt_c", 32'(gnt), 32'h4);
    check_val("single.q_c",   32'(q),   32'hA5);
    req = 4'b1000; wdata = 32'h7700_0000;
    cycle("ptr3");
    check_val("ptr3.gnt_c", 32'(gnt), 32'h8);

    // full rotation from ptr 0
    async_reset("rst_a");
    req = 4'b1111; wdata = 32'h4433_2211;
    for (int k = 0; k < 4; k++) begin
      cycle("rot");
      check_val("rot.gnt_c", 32'(gnt), 32'(1 << k));
      check_val("rot.q_c",   32'(q),   32'('h11 * (k + 1)));
    end

    // lock by requester 1 while requester 0 waits
    req = 4'b0001; lock = 4'b0000;
    cycle("pre_lock");
    req = 4'b0011; lock = 4'b0010; wdata = 32'h0000_5A00;
    for (int k = 0; k < 3; k++) begin
      cycle("lock1");
      check_val("lock1.gnt_c",  32'(gnt),  32'h2);
      check_val("lock1.busy_c", 32'(busy), 32'h1);
    end
    req = 4'b0001; lock = 4'b0000;
    cycle("release");
    check_val("release.gnt_c", 32'(gnt), 32'h0);
    cycle("after_rel");
    check_val("after_rel.gnt_c", 32'(gnt), 32'h1);

    // non-owner lock is ignored while owner 1 holds
    req = 4'b1010; lock = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cycle("nonowner");
      check_val("nonowner.gnt_c", 32'(gnt), 32'h2);
    end
    req = 4'b1000; lock = 4'b1000;
    cycle("no_rel");
    check_val("no_rel.gnt_c", 32'(gnt), 32'h0);
    cycle("no_win3");
    check_val("no_win3.gnt_c", 32'(gnt), 32'h8);
    req = 4'b0000; lock = 4'b0000;
    cycle("no_drop");

    // asynchronous reset in the middle of a lock
    req = 4'b0010; lock = 4'b0010; wdata = 32'hDEAD_BEEF;
    cycle("pre_rst");
    check_val("pre_rst.busy_c", 32'(busy), 32'h1);
    async_reset("rst_mid");
    req = 4'b0110; lock = 4'b0000;
    cycle("post_rst");
    check_val("post_rst.gnt_c", 32'(gnt), 32'h2);

`ifdef ARB_TIMEOUT_EN
    async_reset("rst_to");
    req = 4'b0011; lock = 4'b0001; wdata = 32'h0000_C3B4;
    n_g0 = 0; n_to = 0;
    for (int k = 0; k < 10; k++) begin
      cycle("tmo");
      if (gnt == 4'b0001) n_g0++;
      if (timeout) n_to++;
    end
    check_val("tmo.grants",  32'(n_g0), 32'(ML));
    check_val("tmo.pulses",  32'(n_to), 32'h1);
    check_val("tmo.next",    32'(gnt),  32'h2);
`else
    n_g0 = 0; n_to = 0;
`endif

    // randomized traffic
    req = '0; lock = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) begin
          // waiting requesters keep asking
        end else if (gnt[i] && lock[i] && $urandom_range(0, 3) != 0) begin
          // owner keeps its lock a while longer
        end else begin
          req[i]  = ($urandom_range(0, 2) == 0);
          lock[i] = req[i] && ($urandom_range(0, 2) == 0);
        end
      end
      wdata = $urandom;
      cycle("rand");
      if (c % 150 == 77) begin
        async_reset("rand_rst");
        req = '0; lock = '0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
